// File: rtl/fifo_serializer_if.sv
// Handshake bundle between the FIFO side and the serializer: pop interface in,
// serial line and frame status out.
interface fifo_serializer_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_out;
  logic             shift_out;
  logic             tx;
  logic             busy;
  logic             done;

  modport master (
    output enable, fifo_empty, fifo_out,
    input  shift_out, tx, busy, done
  );

  modport slave (
    input  enable, fifo_empty, fifo_out,
    output shift_out, tx, busy, done
  );
endinterface

// File: rtl/fifo_serializer.sv
// Pops words from the register FIFO and sends each one as a start/data/stop
// serial frame, LSB first, chaining frames without a gap while data is queued.
module fifo_serializer #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input logic              clk,
  input logic              res,
  fifo_serializer_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cyc;
  logic [BW-1:0]    bit_idx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             tx_q;
  logic             cyc_last;
  logic             pop;

  assign cyc_last   = (cyc == CYC_LAST);
  assign shreg_next = shreg >> 1;

  // Popping at the end of STOP is what lets frames run back-to-back.
  assign pop = !res && bus.enable && !bus.fifo_empty &&
               ((state == IDLE) || ((state == STOP) && cyc_last));

  assign bus.shift_out = pop;
  assign bus.tx        = tx_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == STOP) && cyc_last;

  // tx is loaded with the level of the state being entered, so the line
  // trails the state register by nothing and a frame spans exactly its states.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= IDLE;
      cyc     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            state <= START;
            cyc   <= '0;
            shreg <= bus.fifo_out;
            tx_q  <= 1'b0;
          end
        end
        START: begin
          if (cyc_last) begin
            state   <= DATA;
            cyc     <= '0;
            bit_idx <= '0;
            tx_q    <= shreg[0];
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        DATA: begin
          if (cyc_last) begin
            cyc <= '0;
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg_next;
              tx_q    <= shreg_next[0];
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        STOP: begin
          if (cyc_last) begin
            cyc <= '0;
            if (pop) begin
              state <= START;
              shreg <= bus.fifo_out;
              tx_q  <= 1'b0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench for fifo_serializer: a queue stands in for the FIFO, and two
// instances cover CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_fifo_serializer;
  logic clk;
  logic res;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int pop0 = 0;
  int pop1 = 0;

  fifo_serializer_if #(.WIDTH(4)) ifc0 ();
  fifo_serializer_if #(.WIDTH(4)) ifc1 ();

  fifo_serializer #(.WIDTH(4), .CLKS_PER_BIT(4)) dut0 (.clk(clk), .res(res), .bus(ifc0.slave));
  fifo_serializer #(.WIDTH(4), .CLKS_PER_BIT(1)) dut1 (.clk(clk), .res(res), .bus(ifc1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] expand(input logic [5:0] f);
    logic [23:0] r;
    r = '0;
    for (int k = 5; k >= 0; k--) r = {r[19:0], {4{f[k]}}};
    return r;
  endfunction

  task automatic refresh();
    ifc0.fifo_empty = (q0.size() == 0);
    ifc0.fifo_out   = (q0.size() > 0) ? q0[0] : 4'h0;
    ifc1.fifo_empty = (q1.size() == 0);
    ifc1.fifo_out   = (q1.size() > 0) ? q1[0] : 4'h0;
  endtask

  // One clock: note the pop strobes just before the edge, retire the popped
  // words just after it, and return on the following falling edge.
  task automatic tick();
    logic p0, p1;
    #1;
    p0 = ifc0.shift_out;
    p1 = ifc1.shift_out;
    @(posedge clk);
    #1;
    if (p0) begin
      pop0++;
      if (q0.size() > 0) void'(q0.pop_front());
    end
    if (p1) begin
      pop1++;
      if (q1.size() > 0) void'(q1.pop_front());
    end
    refresh();
    @(negedge clk);
  endtask

  task automatic test_reset();
    res = 1'b1;
    q0.push_back(4'h7);
    refresh();
    ifc0.enable = 1'b1;
    tick();
    tick();
    #1;
    tests_run++;
    if (ifc0.shift_out !== 1'b0 || ifc0.tx !== 1'b1 || ifc0.busy !== 1'b0 || ifc0.done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got shift_out=%b tx=%b busy=%b done=%b, want 0 1 0 0",
               ifc0.shift_out, ifc0.tx, ifc0.busy, ifc0.done);
    end
    tests_run++;
    if (pop0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_pop: got %0d pops, want 0", pop0);
    end
    q0.delete();
    refresh();
    @(negedge clk);
    res = 1'b0;
    tick();
    tests_run++;
    if (ifc0.tx !== 1'b1 || ifc0.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL empty_idle: got tx=%b busy=%b, want 1 0", ifc0.tx, ifc0.busy);
    end
  endtask

  task automatic test_single_word();
    logic [23:0] vec;
    int start_pops, done_cnt, done_at, busy_cnt;
    vec = '0; done_cnt = 0; done_at = 0; busy_cnt = 0;
    start_pops = pop0;
    q0.push_back(4'b1011);
    refresh();
    ifc0.enable = 1'b1;
    #1;
    tests_run++;
    if (ifc0.shift_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_pop_strobe: got %b, want 1", ifc0.shift_out);
    end
    for (int i = 1; i <= 24; i++) begin
      tick();
      vec = {vec[22:0], ifc0.tx};
      if (ifc0.busy === 1'b1) busy_cnt++;
      if (ifc0.done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
    end
    tests_run++;
    if (vec !== 24'b0000_1111_1111_0000_1111_1111) begin
      tests_failed++;
      $display("[TB] FAIL single_frame: got %b, want %b", vec, 24'b0000_1111_1111_0000_1111_1111);
    end
    tests_run++;
    if (done_cnt !== 1 || done_at !== 24) begin
      tests_failed++;
      $display("[TB] FAIL single_done: got %0d pulses last at cycle %0d, want 1 at 24", done_cnt, done_at);
    end
    tests_run++;
    if (busy_cnt !== 24 || pop0 - start_pops !== 1) begin
      tests_failed++;
      $display("[TB] FAIL single_busy_pops: got busy=%0d pops=%0d, want 24 1", busy_cnt, pop0 - start_pops);
    end
    tick();
    tests_run++;
    if (ifc0.tx !== 1'b1 || ifc0.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_back_idle: got tx=%b busy=%b, want 1 0", ifc0.tx, ifc0.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [71:0] vec;
    logic [71:0] want;
    int start_pops, done_cnt, busy_cnt;
    vec = '0; done_cnt = 0; busy_cnt = 0;
    want = {expand(6'b010001), expand(6'b001011), expand(6'b011111)};
    ifc0.enable = 1'b0;
    q0.push_back(4'h1);
    q0.push_back(4'hA);
    q0.push_back(4'hF);
    refresh();
    tick();
    start_pops = pop0;
    ifc0.enable = 1'b1;
    for (int i = 1; i <= 72; i++) begin
      tick();
      vec = {vec[70:0], ifc0.tx};
      if (ifc0.busy === 1'b1) busy_cnt++;
      if (ifc0.done === 1'b1) done_cnt++;
    end
    tests_run++;
    if (vec !== want) begin
      tests_failed++;
      $display("[TB] FAIL b2b_stream: got %h, want %h", vec, want);
    end
    tests_run++;
    if (pop0 - start_pops !== 3 || done_cnt !== 3) begin
      tests_failed++;
      $display("[TB] FAIL b2b_counts: got pops=%0d done=%0d, want 3 3", pop0 - start_pops, done_cnt);
    end
    tests_run++;
    if (busy_cnt !== 72) begin
      tests_failed++;
      $display("[TB] FAIL b2b_busy: got %0d busy cycles, want 72", busy_cnt);
    end
    tick();
    tests_run++;
    if (ifc0.tx !== 1'b1 || ifc0.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_idle: got tx=%b busy=%b, want 1 0", ifc0.tx, ifc0.busy);
    end
  endtask

  task automatic test_enable_drop();
    logic [23:0] vec;
    int start_pops, bad_idle;
    vec = '0; bad_idle = 0;
    start_pops = pop0;
    q0.push_back(4'h6);
    q0.push_back(4'h9);
    refresh();
    ifc0.enable = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      vec = {vec[22:0], ifc0.tx};
      if (i == 10) ifc0.enable = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ifc0.tx !== 1'b1 || ifc0.busy !== 1'b0 || ifc0.shift_out !== 1'b0) bad_idle++;
    end
    tests_run++;
    if (vec !== expand(6'b001101)) begin
      tests_failed++;
      $display("[TB] FAIL enable_frame: got %b, want %b", vec, expand(6'b001101));
    end
    tests_run++;
    if (pop0 - start_pops !== 1 || q0.size() !== 1) begin
      tests_failed++;
      $display("[TB] FAIL enable_one_pop: got pops=%0d left=%0d, want 1 1", pop0 - start_pops, q0.size());
    end
    tests_run++;
    if (bad_idle !== 0) begin
      tests_failed++;
      $display("[TB] FAIL enable_idle: got %0d non-idle cycles, want 0", bad_idle);
    end
    q0.delete();
    refresh();
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] vec;
    int start_pops;
    vec = '0;
    start_pops = pop0;
    q0.push_back(4'hC);
    q0.push_back(4'h3);
    refresh();
    ifc0.enable = 1'b1;
    for (int i = 1; i <= 14; i++) tick();
    res = 1'b1;
    #1;
    tests_run++;
    if (ifc0.tx !== 1'b1 || ifc0.busy !== 1'b0 || ifc0.shift_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got tx=%b busy=%b shift_out=%b, want 1 0 0",
               ifc0.tx, ifc0.busy, ifc0.shift_out);
    end
    tick();
    tests_run++;
    if (pop0 - start_pops !== 1 || q0.size() !== 1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_pops: got pops=%0d left=%0d, want 1 1", pop0 - start_pops, q0.size());
    end
    res = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      vec = {vec[22:0], ifc0.tx};
    end
    tests_run++;
    if (vec !== expand(6'b011001)) begin
      tests_failed++;
      $display("[TB] FAIL midreset_fresh_frame: got %b, want %b", vec, expand(6'b011001));
    end
    tests_run++;
    if (pop0 - start_pops !== 2 || q0.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_total_pops: got pops=%0d left=%0d, want 2 0", pop0 - start_pops, q0.size());
    end
    tick();
  endtask

  task automatic test_one_clk_per_bit();
    logic [11:0] vec;
    int start_pops, done_cnt;
    vec = '0; done_cnt = 0;
    start_pops = pop1;
    q1.push_back(4'h5);
    q1.push_back(4'h3);
    refresh();
    ifc1.enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      vec = {vec[10:0], ifc1.tx};
      if (ifc1.done === 1'b1) done_cnt++;
    end
    tests_run++;
    if (vec !== 12'b010101_011001) begin
      tests_failed++;
      $display("[TB] FAIL fast_stream: got %b, want %b", vec, 12'b010101_011001);
    end
    tests_run++;
    if (pop1 - start_pops !== 2 || done_cnt !== 2) begin
      tests_failed++;
      $display("[TB] FAIL fast_counts: got pops=%0d done=%0d, want 2 2", pop1 - start_pops, done_cnt);
    end
    tick();
    tests_run++;
    if (ifc1.tx !== 1'b1 || ifc1.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fast_idle: got tx=%b busy=%b, want 1 0", ifc1.tx, ifc1.busy);
    end
  endtask

  initial begin
    res = 1'b1;
    ifc0.enable = 1'b0;
    ifc1.enable = 1'b0;
    refresh();
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    test_one_clk_per_bit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
